// File: rtl/dti_fifo_wr_ptr_ctrl_if.sv
// Write-side bus of the dual-clock FIFO pointer controller: producer handshake,
// memory write address, Gray pointer exchange with the read domain, and status.
interface dti_fifo_wr_ptr_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 4
);
    logic                  wr_req;
    logic                  wr_ack;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [ADDR_WIDTH:0]   wr_ptr_gray;
    logic [ADDR_WIDTH:0]   rd_ptr_gray_sync;
    logic                  full;
    logic                  almost_full;
    logic [ADDR_WIDTH:0]   free_cnt;
    logic                  gray_err;

    // Producer / read-synchronizer side
    modport master (
        output wr_req,
        output rd_ptr_gray_sync,
        input  wr_ack,
        input  wr_addr,
        input  wr_ptr_gray,
        input  full,
        input  almost_full,
        input  free_cnt,
        input  gray_err
    );

    // Pointer controller side
    modport slave (
        input  wr_req,
        input  rd_ptr_gray_sync,
        output wr_ack,
        output wr_addr,
        output wr_ptr_gray,
        output full,
        output almost_full,
        output free_cnt,
        output gray_err
    );
endinterface

// File: rtl/dti_fifo_wr_ptr_ctrl.sv
// Write-domain pointer controller for a dual-clock FIFO. Keeps the binary write
// pointer, publishes its registered Gray form, decodes the synchronized Gray read
// pointer and registers full / almost_full / free_cnt from next-state values.
module dti_fifo_wr_ptr_ctrl #(
    parameter int unsigned ADDR_WIDTH      = 4,
    parameter int unsigned ALMOST_FULL_THR = 2
) (
    input logic                    clk,
    input logic                    reset,
    dti_fifo_wr_ptr_ctrl_if.slave  bus
);
    localparam int unsigned PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] DEPTH_V = PW'(1) << ADDR_WIDTH;
    localparam logic [PW-1:0] THR_V   = PW'(ALMOST_FULL_THR);

    logic [PW-1:0] wr_ptr_bin_q,  wr_ptr_bin_d;
    logic [PW-1:0] wr_ptr_gray_q, wr_ptr_gray_d;
    logic [PW-1:0] free_cnt_q,    free_cnt_d;
    logic          full_q,        full_d;
    logic          almost_full_q, almost_full_d;
    logic          gray_err_q,    gray_err_d;
    logic [PW-1:0] rd_gray_q;
    logic          chk_en_q;
    logic [PW-1:0] rd_bin;
    logic [PW-1:0] used_d;
    logic          wr_ack;

    // Push handshake and write address; full is registered so no long path
    assign wr_ack      = bus.wr_req & ~full_q;
    assign bus.wr_ack  = wr_ack;
    assign bus.wr_addr = wr_ptr_bin_q[ADDR_WIDTH-1:0];

    // Next-state pointer, Gray decode of the read pointer and derived status
    always_comb begin
        rd_bin = '0;
        // Each binary bit is the XOR of all Gray bits at or above it
        for (int unsigned i = 0; i < PW; i++) begin
            rd_bin[i] = ^(bus.rd_ptr_gray_sync >> i);
        end
        wr_ptr_bin_d  = wr_ptr_bin_q + PW'(wr_ack);
        wr_ptr_gray_d = wr_ptr_bin_d ^ (wr_ptr_bin_d >> 1);
        used_d        = wr_ptr_bin_d - rd_bin;
        free_cnt_d    = DEPTH_V - used_d;
        full_d        = (used_d == DEPTH_V);
        almost_full_d = (free_cnt_d <= THR_V);
        gray_err_d    = gray_err_q;
        if (chk_en_q && ($countones(bus.rd_ptr_gray_sync ^ rd_gray_q) > 1)) begin
            gray_err_d = 1'b1;
        end
    end

    // Pointer, status and Gray-check state; status updates together with wr_ptr_gray
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_bin_q  <= '0;
            wr_ptr_gray_q <= '0;
            free_cnt_q    <= DEPTH_V;
            full_q        <= 1'b0;
            almost_full_q <= 1'b0;
            gray_err_q    <= 1'b0;
            rd_gray_q     <= '0;
            chk_en_q      <= 1'b0;
        end else begin
            wr_ptr_bin_q  <= wr_ptr_bin_d;
            wr_ptr_gray_q <= wr_ptr_gray_d;
            free_cnt_q    <= free_cnt_d;
            full_q        <= full_d;
            almost_full_q <= almost_full_d;
            gray_err_q    <= gray_err_d;
            rd_gray_q     <= bus.rd_ptr_gray_sync;
            chk_en_q      <= 1'b1;
        end
    end

    assign bus.wr_ptr_gray = wr_ptr_gray_q;
    assign bus.free_cnt    = free_cnt_q;
    assign bus.full        = full_q;
    assign bus.almost_full = almost_full_q;
    assign bus.gray_err    = gray_err_q;
endmodule

// File: tb/tb_dti_fifo_wr_ptr_ctrl.sv
// Randomized and directed bench for the FIFO write-pointer controller with a
// count-based occupancy model (total writes vs. total reads).
module tb_dti_fifo_wr_ptr_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;

    dti_fifo_wr_ptr_ctrl_if #(.ADDR_WIDTH(4)) bus ();

    dti_fifo_wr_ptr_ctrl #(.ADDR_WIDTH(4), .ALMOST_FULL_THR(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Model state: total accepted writes, read position shown on the bus
    int wcnt    = 0;
    int rd_pos  = 0;
    int m_free  = 16;
    bit m_err   = 1'b0;
    bit m_first = 1'b1;
    logic [4:0] m_prev_g = '0;
    bit mon_en  = 1'b0;
    bit step_chk = 1'b0;
    logic [4:0] prev_wg = '0;

    function automatic logic [4:0] gray5(input int v);
        logic [4:0] b;
        b = v[4:0];
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model advanced at each clock edge
    always @(posedge clk) begin
        if (reset) begin
            wcnt    = 0;
            m_free  = 16;
            m_err   = 1'b0;
            m_first = 1'b1;
            m_prev_g = '0;
        end else begin
            if (bus.wr_req && m_free != 0) wcnt++;
            if (!m_first && $countones(bus.rd_ptr_gray_sync ^ m_prev_g) > 1) m_err = 1'b1;
            m_first  = 1'b0;
            m_prev_g = bus.rd_ptr_gray_sync;
            m_free   = 16 - ((wcnt - rd_pos) & 31);
        end
    end

    // Compare all outputs against the model mid-cycle
    always @(negedge clk) begin
        if (mon_en) begin
            chk("wr_ptr_gray", 32'(bus.wr_ptr_gray), 32'(gray5(wcnt)));
            chk("wr_addr",     32'(bus.wr_addr),     32'(wcnt & 15));
            chk("free_cnt",    32'(bus.free_cnt),    32'(m_free));
            chk("full",        32'(bus.full),        32'(m_free == 0));
            chk("almost_full", 32'(bus.almost_full), 32'(m_free <= 2));
            chk("gray_err",    32'(bus.gray_err),    32'(m_err));
            chk("wr_ack",      32'(bus.wr_ack),      32'(bus.wr_req && m_free != 0));
            if (step_chk) begin
                chk("gray_step", 32'($countones(bus.wr_ptr_gray ^ prev_wg) <= 1), 32'(1));
            end
            prev_wg = bus.wr_ptr_gray;
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic set_rd(input int pos);
        rd_pos = pos;
        bus.rd_ptr_gray_sync = gray5(pos);
    endtask

    logic [7:0] seq1 [16] = '{8'h01, 8'h03, 8'h02, 8'h06, 8'h07, 8'h05, 8'h04, 8'h0C,
                              8'h0D, 8'h0F, 8'h0E, 8'h0A, 8'h0B, 8'h09, 8'h08, 8'h18};

    initial begin
        int cycles;
        bus.wr_req = 1'b0;
        set_rd(0);
        cyc(2);
        reset  = 1'b0;
        mon_en = 1'b1;
        chk("rst_free", 32'(bus.free_cnt), 32'd16);
        chk("rst_gray", 32'(bus.wr_ptr_gray), 32'd0);

        // 16 pushes into an empty FIFO
        bus.wr_req = 1'b1;
        for (int i = 0; i < 16; i++) begin
            cyc(1);
            chk("fill_gray", 32'(bus.wr_ptr_gray), 32'(seq1[i]));
        end
        chk("fill_full", 32'(bus.full), 32'd1);
        chk("fill_free", 32'(bus.free_cnt), 32'd0);
        #1 chk("req17_ack", 32'(bus.wr_ack), 32'd0);
        cyc(1);
        chk("req17_gray", 32'(bus.wr_ptr_gray), 32'h18);

        // Read side frees one entry
        bus.wr_req = 1'b0;
        set_rd(1);
        cyc(1);
        chk("rd1_full", 32'(bus.full), 32'd0);
        chk("rd1_free", 32'(bus.free_cnt), 32'd1);
        chk("rd1_af",   32'(bus.almost_full), 32'd1);
        bus.wr_req = 1'b1;
        #1 chk("rd1_ack",  32'(bus.wr_ack), 32'd1);
        chk("rd1_addr", 32'(bus.wr_addr), 32'd0);
        cyc(1);
        bus.wr_req = 1'b0;
        chk("refull", 32'(bus.full), 32'd1);

        // almost_full threshold
        reset = 1'b1;
        set_rd(0);
        cyc(1);
        reset = 1'b0;
        bus.wr_req = 1'b1;
        cyc(13);
        bus.wr_req = 1'b0;
        chk("e13_free", 32'(bus.free_cnt), 32'd3);
        chk("e13_af",   32'(bus.almost_full), 32'd0);
        bus.wr_req = 1'b1;
        cyc(1);
        bus.wr_req = 1'b0;
        chk("e14_free", 32'(bus.free_cnt), 32'd2);
        chk("e14_af",   32'(bus.almost_full), 32'd1);

        // Reset mid-stream with 9 entries
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        bus.wr_req = 1'b1;
        cyc(9);
        chk("e9_free", 32'(bus.free_cnt), 32'd7);
        reset = 1'b1;
        cyc(1);
        chk("mid_rst_free", 32'(bus.free_cnt), 32'd16);
        chk("mid_rst_full", 32'(bus.full), 32'd0);
        chk("mid_rst_gray", 32'(bus.wr_ptr_gray), 32'd0);
        reset = 1'b0;
        bus.wr_req = 1'b0;
        cyc(1);

        // Free-running producer and consumer for 100 pointer laps
        step_chk = 1'b1;
        cycles = 0;
        while (rd_pos < 3200 && cycles < 20000) begin
            bus.wr_req = 1'($urandom_range(0, 99) < 55);
            if (rd_pos < wcnt && $urandom_range(0, 99) < 50) set_rd(rd_pos + 1);
            cyc(1);
            cycles++;
        end
        chk("laps_done", 32'(rd_pos >= 3200), 32'd1);
        chk("laps_err",  32'(bus.gray_err), 32'd0);
        step_chk = 1'b0;

        // Read pointer breaks the Gray rule
        bus.wr_req = 1'b0;
        reset = 1'b1;
        set_rd(0);
        cyc(1);
        reset = 1'b0;
        bus.wr_req = 1'b1;
        cyc(4);
        bus.wr_req = 1'b0;
        set_rd(1);
        cyc(1);
        chk("g01_err", 32'(bus.gray_err), 32'd0);
        set_rd(3);
        cyc(1);
        chk("g02_err", 32'(bus.gray_err), 32'd1);
        cyc(3);
        chk("g02_sticky", 32'(bus.gray_err), 32'd1);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        set_rd(0);
        chk("err_clr", 32'(bus.gray_err), 32'd0);
        cyc(2);

        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
